// File: rtl/dmem_bus_if_pkg.sv
// dmem_bus_if_pkg: shared constants and encodings for the data-memory
// bus interface and its lane-alignment helper.
package dmem_bus_if_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane math for one access spanning up to two words.
// Pure combinational; each output is its own assign to keep paths separate.
module dmem_lane_align
    import dmem_bus_if_pkg::*;
(
    input  logic [1:0]        a_i,
    input  logic [1:0]        size_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [2*XLEN-1:0] rdata_i,
    output logic [7:0]        be_full_o,
    output logic [2*XLEN-1:0] wdata_full_o,
    output logic              need_beat1_o,
    output logic [XLEN-1:0]   load_o
);

    logic [3:0]      mask;
    logic [XLEN-1:0] bmask;
    logic [4:0]      sh;

    always_comb begin
        mask = 4'h0;
        unique case (size_i)
            SZ_WORD: mask = 4'hF;
            SZ_BYTE: mask = 4'h1;
            SZ_HALF: mask = 4'h3;
            default: mask = 4'h0;
        endcase
    end

    assign sh           = {a_i, 3'b000};
    assign be_full_o    = {4'b0000, mask} << a_i;
    assign wdata_full_o = {{XLEN{1'b0}}, wdata_i} << sh;
    assign need_beat1_o = |be_full_o[7:4];

    assign bmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign load_o = XLEN'(rdata_i >> sh) & bmask;

endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: load/store bus master between execute stage and data memory.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module dmem_bus_if
    import dmem_bus_if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic [1:0]      byte_size,
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    output logic [XLEN-1:0] mem_data_out,
    output logic            mem_read_ready,
    output logic            mem_write_ready,
    output logic            mem_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    state_e state_q, state_d;

    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata0_q, rdata0_d;
    logic [XLEN-1:0] rdata1_q, rdata1_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic            err_q, err_d;

    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic            rd_rdy_q, rd_rdy_d;
    logic            wr_rdy_q, wr_rdy_d;
    logic            merr_q, merr_d;
    logic [XLEN-1:0] dout_q, dout_d;

    logic            start;
    logic            bad_acc;
    logic [7:0]      be_full;
    logic [2*XLEN-1:0] wdata_full;
    logic            need_beat1;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] beat0_addr;

    // Capture values are looked at through their _d view so the first
    // request beat can be registered on the same edge as the capture.
    assign start   = (state_q == IDLE) & (mem_read_en | mem_write_en);
    assign addr_d  = start ? mem_addr : addr_q;
    assign size_d  = start ? byte_size : size_q;
    assign wdata_d = start ? mem_data : wdata_q;
    assign we_d    = start ? mem_write_en : we_q;
    assign bad_acc = (size_d == SZ_ILL) | (need_beat1 & ~SPLIT_EN);
    assign err_d   = start ? bad_acc : err_q;

    assign beat0_addr = {addr_d[XLEN-1:2], 2'b00};

    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (start) begin
            rdata0_d = '0;
            rdata1_d = '0;
        end else if (state_q == WAIT0 && bus_rvalid) begin
            rdata0_d = bus_rdata;
        end else if (state_q == WAIT1 && bus_rvalid) begin
            rdata1_d = bus_rdata;
        end
    end

    dmem_lane_align u_align (
        .a_i          (addr_d[1:0]),
        .size_i       (size_d),
        .wdata_i      (wdata_d),
        .rdata_i      ({rdata1_d, rdata0_d}),
        .be_full_o    (be_full),
        .wdata_full_o (wdata_full),
        .need_beat1_o (need_beat1),
        .load_o       (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = bad_acc ? RESP : REQ0;
            REQ0:    if (bus_gnt) state_d = WAIT0;
            WAIT0:   if (bus_rvalid) state_d = need_beat1 ? REQ1 : RESP;
            REQ1:    if (bus_gnt) state_d = WAIT1;
            WAIT1:   if (bus_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_be_d    = 4'h0;
        bus_wdata_d = '0;
        rd_rdy_d    = 1'b0;
        wr_rdy_d    = 1'b0;
        merr_d      = 1'b0;
        dout_d      = dout_q;
        unique case (state_d)
            REQ0: begin
                bus_req_d   = 1'b1;
                bus_we_d    = we_d;
                bus_addr_d  = beat0_addr;
                bus_be_d    = be_full[3:0];
                bus_wdata_d = we_d ? wdata_full[XLEN-1:0] : '0;
            end
            REQ1: begin
                bus_req_d   = 1'b1;
                bus_we_d    = we_d;
                bus_addr_d  = beat0_addr + XLEN'(4);
                bus_be_d    = be_full[7:4];
                bus_wdata_d = we_d ? wdata_full[2*XLEN-1:XLEN] : '0;
            end
            RESP: begin
                rd_rdy_d = ~we_d;
                wr_rdy_d = we_d;
                merr_d   = err_d;
                if (!we_d) dout_d = err_d ? '0 : load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            size_q   <= size_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= '0;
            rd_rdy_q    <= 1'b0;
            wr_rdy_q    <= 1'b0;
            merr_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rd_rdy_q    <= rd_rdy_d;
            wr_rdy_q    <= wr_rdy_d;
            merr_q      <= merr_d;
            dout_q      <= dout_d;
        end
    end

    assign bus_req         = bus_req_q;
    assign bus_we          = bus_we_q;
    assign bus_addr        = bus_addr_q;
    assign bus_be          = bus_be_q;
    assign bus_wdata       = bus_wdata_q;
    assign mem_read_ready  = rd_rdy_q;
    assign mem_write_ready = wr_rdy_q;
    assign mem_err         = merr_q;
    assign mem_data_out    = dout_q;

endmodule

// File: doc/dmem_bus_if.md
# dmem_bus_if

Data-memory bus interface directly downstream of the load/store execute unit. It accepts one level-held load/store request (address, size, store data) and performs the word-aligned bus transaction(s) with byte enables. It returns lane-aligned load data, or store completion, as a one-cycle ready pulse. It sits between the execute-stage memory unit and the data SRAM/peripheral bus.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_addr  in  32  byte address from execute unit
- mem_data  in  32  store data, right-justified
- byte_size  in  2  0 = word, 1 = byte, 2 = half, 3 = illegal
- mem_read_en  in  1  load request, held until ready
- mem_write_en  in  1  store request, held until ready
- mem_data_out  out  32  load data, right-justified, zero-extended
- mem_read_ready  out  1  one-cycle pulse: load done
- mem_write_ready  out  1  one-cycle pulse: store done
- mem_err  out  1  one-cycle pulse with ready: illegal size or unsupported misalignment
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, bits [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-positioned write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  response valid (reads and writes)
- bus_rdata  in  32  read data

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: if mem_write_en, capture a store; else if mem_read_en, capture a load. Write has priority when both are set. Capture addr, size and data, then go to REQ0.
- Capture-time checks: size 3 -> RESP with mem_err=1 and no bus access.
- Lane math, a = addr[1:0]:
  - bytes n = 4/1/2 for size 0/1/2.
  - be_full = ((1<<n)-1) << a, 8 bits wide.
  - wdata_full = data << 8a, 64 bits wide.
  - Beat 0 uses the low 4 bits of be_full and the low 32 bits of wdata_full, at address {addr[31:2],2'b00}.
  - Beat 1 is needed iff be_full[7:4] != 0. It uses be_full[7:4] and wdata_full[63:32], at beat-0 address + 4, with wrap-around mod 2^32.
- REQ0: hold bus_req=1 with beat-0 fields until bus_gnt; then go to WAIT0.
- WAIT0: on bus_rvalid, latch rdata0; then go to REQ1 if a second beat is needed, else RESP.
- REQ1 and WAIT1 behave the same for beat 1, latching rdata1.
- Load result: ({rdata1,rdata0} >> 8a), masked to n bytes and zero-extended. For a single beat, rdata1 = 0.
- RESP: pulse mem_read_ready or mem_write_ready (and mem_err if flagged) for exactly one cycle, then go to IDLE.
- bus_rvalid is ignored in IDLE, REQ0, REQ1 and RESP.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - internal captures 0
- Reset mid-transaction drops bus_req immediately; a late bus_rvalid after reset is ignored.
- All outputs are registered.
- Aligned single-beat latency, with gnt in the first REQ0 cycle and rvalid the next cycle:
  - Enable seen at edge T.
  - bus_req high in cycle T+1.
  - WAIT0 in cycle T+2.
  - Ready high in cycle T+3.
- Each extra cycle of gnt or rvalid wait adds one cycle. A split access adds two cycles minimum.
- bus_addr, bus_be, bus_wdata and bus_we stay stable while bus_req=1 and gnt=0.
- The ready pulse is one cycle. The requester drops its enable on the edge that samples ready, so IDLE never re-accepts the same request.
- mem_data_out holds its value until the next load completes.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined: misaligned half/word accesses crossing a word boundary are split into two beats as above.
- Undefined: any access needing beat 1 goes IDLE -> RESP with mem_err=1 and no bus traffic. Load data is then 0 and stores have no effect. Accesses that are misaligned but stay inside one word (e.g. half at a=1) still proceed as a single beat.

## Structure
- Shared package holds:
  - size codes SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2
  - state encoding
  - XLEN constant
- Sub-module dmem_lane_align: combinational. Inputs addr[1:0], size, store data, {rdata1,rdata0}. Outputs be_full[7:0], wdata_full[63:0], need_beat1, load result. The FSM stays in dmem_bus_if.

## Test plan
- Aligned lw, addr 0x100, gnt immediately, rvalid next cycle, rdata 0xDEADBEEF -> bus_be=1111, bus_addr=0x100, mem_data_out=0xDEADBEEF, read_ready pulse at T+3.
- sb, addr 0x203, data 0x000000A5 -> bus_be=1000, bus_wdata=0xA5000000, write_ready one cycle, mem_err=0.
- lh, addr 0x302, rdata 0x1234_5678 -> be=1100, mem_data_out=0x00001234; gnt delayed 3 cycles -> ready delayed 3 cycles, bus fields stable.
- sw, addr 0x0FF, split enabled, data 0x11223344 -> beat0 addr 0x0FC be=1000 wdata=0x44000000; beat1 addr 0x100 be=0111 wdata=0x00112233. Macro off -> mem_err with write_ready and no bus_req.
- byte_size=3 -> mem_err + read_ready with no bus_req. Both enables set -> store performed. rst asserted in WAIT0 -> outputs 0 immediately and later rvalid ignored.
